// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NREAD combinational read
// ports, one write port, and a per-register busy scoreboard for RAW stalls.
// Optional build macro: REGFILE_BYPASS_EN. When defined, a write in flight
// is forwarded to matching read ports in the same cycle.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREAD*ADDR_W-1:0]   readReg,
  output logic [NREAD*DATA_W-1:0]   data,
  output logic [NREAD-1:0]          readBusy,
  input  logic [ADDR_W-1:0]         writeReg,
  input  logic [DATA_W-1:0]         writeData,
  input  logic                      RegWrite,
  input  logic [ADDR_W-1:0]         reserveReg,
  input  logic                      reserve,
  output logic [ADDR_W:0]           busyCount
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic wrEn;
  logic rsvEn;
  logic setNew;
  logic clrOld;

  logic [ADDR_W-1:0] readAddr [NREAD];

  // Qualify write/reserve against the hardwired zero register and work out
  // whether this edge adds or removes a busy bit.
  always_comb begin
    wrEn   = RegWrite && !((ZERO_REG != 0) && (writeReg == '0));
    rsvEn  = reserve  && !((ZERO_REG != 0) && (reserveReg == '0));
    setNew = rsvEn && !busy[reserveReg];
    // A clear to the register being reserved on the same edge loses to the
    // reserve, so it never decrements the count.
    clrOld = wrEn && busy[writeReg] && !(rsvEn && (reserveReg == writeReg));
  end

  // Register storage: reset clears everything, otherwise one write per edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn) begin
      regs[writeReg] <= writeData;
    end
  end

  // Busy scoreboard: writeback clears, reserve sets; reserve is applied last
  // so the new producer wins on a same-register collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wrEn) begin
        busy[writeReg] <= 1'b0;
      end
      if (rsvEn) begin
        busy[reserveReg] <= 1'b1;
      end
    end
  end

  // Running popcount of the busy vector, tracked incrementally.
  always_ff @(posedge clk) begin
    if (reset) begin
      busyCount <= '0;
    end else if (setNew && !clrOld) begin
      busyCount <= busyCount + COUNT_ONE;
    end else if (clrOld && !setNew) begin
      busyCount <= busyCount - COUNT_ONE;
    end
  end

  // Unpack the read address bus.
  always_comb begin
    for (int unsigned i = 0; i < NREAD; i++) begin
      readAddr[i] = readReg[i*ADDR_W +: ADDR_W];
    end
  end

  // Combinational read ports with optional write-through forwarding.
  always_comb begin
    data     = '0;
    readBusy = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      if ((ZERO_REG != 0) && (readAddr[i] == '0)) begin
        data[i*DATA_W +: DATA_W] = '0;
        readBusy[i]              = 1'b0;
      end else begin
        data[i*DATA_W +: DATA_W] = regs[readAddr[i]];
        readBusy[i]              = busy[readAddr[i]];
`ifdef REGFILE_BYPASS_EN
        if (wrEn && (readAddr[i] == writeReg)) begin
          data[i*DATA_W +: DATA_W] = writeData;
          // A reserve of the same register this cycle keeps it busy.
          if (!(reserve && (reserveReg == writeReg))) begin
            readBusy[i] = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule
